// File: rtl/img_dmem_packer_pkg.sv
// ----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image-to-DMEM packer: the capture FSM state
// encoding and the geometry of the packed DMEM word.
//   PIX_W    : width of one pixel lane inside a DMEM word
//   LANES    : pixels packed into one DMEM word
//   DMEM_AW  : DMEM word-address width
//   DMEM_DW  : DMEM word width (LANES * PIX_W)
// ----------------------------------------------------------------------------
package img_pkg;

    localparam int PIX_W   = 16;
    localparam int LANES   = 16;
    localparam int DMEM_AW = 7;
    localparam int DMEM_DW = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/img_dmem_packer.sv
// ----------------------------------------------------------------------------
// img_dmem_packer
// Captures one grayscale frame from a pixel stream and packs every 16
// consecutive pixels (zero-extended to PIX_W) into one 256-bit DMEM word,
// issuing a one-cycle write strobe per completed word.
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : CPU arm level; dropping it aborts back to IDLE
//   frame_start  : one-cycle pulse on the first pixel period of a frame
//   pxl_valid    : pxl_data is valid this cycle
//   pxl_data     : 8-bit unsigned pixel
//   dmem_wren    : one-cycle DMEM write strobe
//   dmem_wraddr  : DMEM word address (held between writes)
//   dmem_wrdata  : packed DMEM word (held between writes)
//   ccd_done     : level, whole frame written
//   pxl_cnt      : pixels accepted in the current frame
// ----------------------------------------------------------------------------
module img_dmem_packer #(
    parameter logic [6:0] BASE_ADDR  = 7'd0,
    parameter int          NUM_PIXELS = 784,
    parameter int          PIX_W      = img_pkg::PIX_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         frame_start,
    input  logic                         pxl_valid,
    input  logic [7:0]                   pxl_data,
    output logic                         dmem_wren,
    output logic [img_pkg::DMEM_AW-1:0]  dmem_wraddr,
    output logic [img_pkg::DMEM_DW-1:0]  dmem_wrdata,
    output logic                         ccd_done,
    output logic [9:0]                   pxl_cnt
);

    import img_pkg::*;

    localparam logic [9:0] NUM_PIX_C = 10'(NUM_PIXELS);

    state_e               state_q, state_d;
    logic [9:0]           cnt_q, cnt_d;
    logic [DMEM_AW-1:0]   word_q, word_d;
    logic [DMEM_DW-1:0]   acc_q, acc_d;
    logic                 wren_q, wren_d;
    logic [DMEM_AW-1:0]   wraddr_q, wraddr_d;
    logic [DMEM_DW-1:0]   wrdata_q, wrdata_d;
    logic                 done_q, done_d;

    logic                 start;
    logic                 accept;
    logic [9:0]           base_cnt;
    logic [DMEM_AW-1:0]   base_word;
    logic [DMEM_DW-1:0]   base_acc;
    logic [DMEM_DW-1:0]   new_acc;
    logic [3:0]           lane;

    // Next-state logic. A frame_start restarts from a clean slate in the same
    // cycle, so the counters/accumulator are first replaced by "base" values
    // (zero on a restart) and the pixel of that cycle is packed on top of them.
    // The completed word goes into a separate output register, so the
    // accumulator is free to take lane 0 of the next word immediately.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        acc_d     = acc_q;
        wren_d    = 1'b0;
        wraddr_d  = wraddr_q;
        wrdata_d  = wrdata_q;
        done_d    = done_q;
        start     = 1'b0;
        accept    = 1'b0;
        base_cnt  = cnt_q;
        base_word = word_q;
        base_acc  = acc_q;
        new_acc   = acc_q;
        lane      = cnt_q[3:0];

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            word_d  = '0;
            acc_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (frame_start) begin
                        start   = 1'b1;
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (frame_start) begin
                        start = 1'b1;
                    end else if (cnt_q == NUM_PIX_C) begin
                        // Final word strobe is on the bus this cycle.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        accept = pxl_valid;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (start) begin
                base_cnt  = '0;
                base_word = '0;
                base_acc  = '0;
                accept    = pxl_valid;
                cnt_d     = '0;
                word_d    = '0;
                acc_d     = '0;
            end

            if (accept) begin
                lane    = base_cnt[3:0];
                new_acc = base_acc;
                new_acc[int'(lane)*PIX_W +: PIX_W] = {{(PIX_W-8){1'b0}}, pxl_data};
                cnt_d   = base_cnt + 10'd1;
                if (lane == 4'(LANES-1)) begin
                    wren_d   = 1'b1;
                    wraddr_d = BASE_ADDR + base_word;
                    wrdata_d = new_acc;
                    word_d   = base_word + 7'd1;
                    acc_d    = '0;
                end else begin
                    acc_d = new_acc;
                end
            end
        end
    end

    // State and output registers; reset clears every partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            acc_q    <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            acc_q    <= acc_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            done_q   <= done_d;
        end
    end

    assign dmem_wren   = wren_q;
    assign dmem_wraddr = wraddr_q;
    assign dmem_wrdata = wrdata_q;
    assign ccd_done    = done_q;
    assign pxl_cnt     = cnt_q;

endmodule

// File: tb/tb_img_dmem_packer.sv
// ----------------------------------------------------------------------------
// tb_img_dmem_packer
// Self-checking bench for img_dmem_packer. Frames of pixels are kept in an
// array; expected DMEM words are built directly from that array (word w holds
// pixels 16w..16w+15, lane k = pixel 16w+k) and compared against the writes
// captured from the DMEM port.
// ----------------------------------------------------------------------------
module tb_img_dmem_packer;

    localparam logic [6:0] BASE = 7'd0;
    localparam int         NPIX = 784;
    localparam int         NWORDS = NPIX / 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         frame_start;
    logic         pxl_valid;
    logic [7:0]   pxl_data;
    logic         dmem_wren;
    logic [6:0]   dmem_wraddr;
    logic [255:0] dmem_wrdata;
    logic         ccd_done;
    logic [9:0]   pxl_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0]   pix [0:1023];
    logic [6:0]   addrQ [$];
    logic [255:0] dataQ [$];
    int           cyc = 0;
    int           lastWrenCyc = -1;
    int           doneRiseCyc = -1;
    logic         prevDone = 1'b0;

    img_dmem_packer #(
        .BASE_ADDR  (BASE),
        .NUM_PIXELS (NPIX),
        .PIX_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_start (frame_start),
        .pxl_valid   (pxl_valid),
        .pxl_data    (pxl_data),
        .dmem_wren   (dmem_wren),
        .dmem_wraddr (dmem_wraddr),
        .dmem_wrdata (dmem_wrdata),
        .ccd_done    (ccd_done),
        .pxl_cnt     (pxl_cnt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Write-port monitor: records every strobe and when ccd_done first rises.
    always @(negedge clk) begin
        if (dmem_wren) begin
            addrQ.push_back(dmem_wraddr);
            dataQ.push_back(dmem_wrdata);
            lastWrenCyc = cyc;
        end
        if (ccd_done && !prevDone) doneRiseCyc = cyc;
        prevDone = ccd_done;
        cyc++;
    end

    function automatic logic [255:0] expWord(input int w);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[16*k +: 16] = {8'h00, pix[16*w + k]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearMon();
        addrQ.delete();
        dataQ.delete();
        lastWrenCyc = -1;
        doneRiseCyc = -1;
    endtask

    task automatic rearm();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    // Drives one frame: frame_start with pixel 0, then the remaining pixels,
    // optionally with an idle (garbage-data) cycle between valid cycles.
    task automatic applyStimulus(input int npix, input bit gapped, input bit randVals);
        int  i;
        bit  phase;
        for (int k = 0; k < npix; k++) pix[k] = randVals ? 8'($urandom) : 8'(k);
        i = 0;
        phase = 1'b1;
        frame_start = 1'b1;
        while (i < npix) begin
            if (!gapped || phase) begin
                pxl_valid = 1'b1;
                pxl_data  = pix[i];
                i++;
            end else begin
                pxl_valid = 1'b0;
                pxl_data  = 8'($urandom);
            end
            tick();
            frame_start = 1'b0;
            phase = !phase;
        end
        pxl_valid = 1'b0;
    endtask

    task automatic checkWrites(input string tag, input int n);
        int m;
        checkOutput({tag, "_count"}, 256'(addrQ.size()), 256'(n));
        m = (addrQ.size() < n) ? addrQ.size() : n;
        for (int w = 0; w < m; w++) begin
            checkOutput($sformatf("%s_addr%0d", tag, w), 256'(addrQ[w]), 256'(7'(BASE + 7'(w))));
            checkOutput($sformatf("%s_data%0d", tag, w), dataQ[w], expWord(w));
        end
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (!ccd_done && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done_seen"}, 256'(ccd_done), 256'(1'b1));
        tick();
        checkOutput({tag, "_done_latency"}, 256'(doneRiseCyc), 256'(lastWrenCyc + 1));
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        frame_start = 1'b0;
        pxl_valid   = 1'b0;
        pxl_data    = 8'h00;

        // Reset values
        tick();
        tick();
        checkOutput("rst_wren",   256'(dmem_wren),   256'(0));
        checkOutput("rst_wraddr", 256'(dmem_wraddr), 256'(0));
        checkOutput("rst_wrdata", dmem_wrdata,       256'(0));
        checkOutput("rst_done",   256'(ccd_done),    256'(0));
        checkOutput("rst_cnt",    256'(pxl_cnt),     256'(0));
        rst_n = 1'b1;
        tick();

        // Full frame, ramp pixels, valid every cycle
        $display("[TB] full frame");
        rearm();
        clearMon();
        applyStimulus(NPIX, 1'b0, 1'b0);
        waitDone("full", 20);
        checkWrites("full", NWORDS);
        if (dataQ.size() > 1)
            checkOutput("full_w1_lane0", 256'(dataQ[1][15:0]), 256'(16'd16));
        checkOutput("full_cnt", 256'(pxl_cnt), 256'(10'd784));
        checkOutput("hold_addr", 256'(dmem_wraddr), 256'(7'(BASE + 7'(NWORDS - 1))));
        checkOutput("hold_data", dmem_wrdata, expWord(NWORDS - 1));

        // Pixels in DONE are ignored
        for (int k = 0; k < 6; k++) begin
            pxl_valid = 1'b1;
            pxl_data  = 8'($urandom);
            tick();
        end
        pxl_valid = 1'b0;
        tick();
        checkOutput("done_ignore_writes", 256'(addrQ.size()), 256'(NWORDS));
        checkOutput("done_ignore_cnt", 256'(pxl_cnt), 256'(10'd784));
        checkOutput("done_held", 256'(ccd_done), 256'(1));

        // Gapped valid, random pixels
        $display("[TB] gapped frame");
        enable = 1'b0;
        tick();
        checkOutput("disable_done", 256'(ccd_done), 256'(0));
        checkOutput("disable_cnt",  256'(pxl_cnt),  256'(0));
        enable = 1'b1;
        tick();
        clearMon();
        applyStimulus(NPIX, 1'b1, 1'b1);
        waitDone("gap", 20);
        checkWrites("gap", NWORDS);
        checkOutput("gap_cnt", 256'(pxl_cnt), 256'(10'd784));

        // Abort after 300 pixels
        $display("[TB] abort");
        rearm();
        clearMon();
        applyStimulus(300, 1'b0, 1'b1);
        checkOutput("abort_cnt_before", 256'(pxl_cnt), 256'(10'd300));
        enable = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checkWrites("abort", 18);
        checkOutput("abort_done", 256'(ccd_done), 256'(0));
        checkOutput("abort_cnt",  256'(pxl_cnt),  256'(0));

        // Restart after 40 pixels
        $display("[TB] restart");
        enable = 1'b1;
        tick();
        applyStimulus(40, 1'b0, 1'b1);
        clearMon();
        applyStimulus(NPIX, 1'b0, 1'b1);
        waitDone("restart", 20);
        checkWrites("restart", NWORDS);

        // Reset at pixel 500
        $display("[TB] reset mid-frame");
        rearm();
        clearMon();
        applyStimulus(500, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_wren",   256'(dmem_wren),   256'(0));
        checkOutput("mrst_wraddr", 256'(dmem_wraddr), 256'(0));
        checkOutput("mrst_wrdata", dmem_wrdata,       256'(0));
        checkOutput("mrst_done",   256'(ccd_done),    256'(0));
        checkOutput("mrst_cnt",    256'(pxl_cnt),     256'(0));
        tick();
        tick();
        rst_n = 1'b1;
        clearMon();
        for (int k = 0; k < 8; k++) begin
            pxl_valid = 1'b1;
            pxl_data  = 8'($urandom);
            tick();
        end
        pxl_valid = 1'b0;
        tick();
        checkOutput("post_rst_nowrite", 256'(addrQ.size()), 256'(0));
        checkOutput("post_rst_cnt", 256'(pxl_cnt), 256'(0));
        clearMon();
        applyStimulus(NPIX, 1'b0, 1'b1);
        waitDone("post_rst", 20);
        checkWrites("post_rst", NWORDS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
